// File: rtl/gpu_dispatch_pkg.sv
// Shared types for the CU dispatch path: top-level block FSM states, per-SIMD
// slot states and the default wave-counter sizing.
package gpu_dispatch_pkg;

  localparam int DEFAULT_MAX_WAVES = 32;
  localparam int WAVE_CNT_W        = $clog2(DEFAULT_MAX_WAVES + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    DISPATCH,
    DRAIN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SLOT_READY,
    SLOT_START,
    SLOT_WORKING
  } slot_e;

endpackage

// File: rtl/wave_dispatcher_find_first_free.sv
// Combinational priority encoder: index of the lowest set bit of a ready mask.
// Shared by the wave dispatcher and the block dispatcher.
module find_first_free #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     ready_mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ready_mask_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wave_dispatcher.sv
// Splits one thread block into wavefronts and hands them to free SIMD slots.
// Optional perf counters (block_cycles, waves_dispatched) under WAVE_DISPATCHER_PERF_EN.
module wave_dispatcher
  import gpu_dispatch_pkg::*;
#(
  parameter int NUM_SIMD  = 4,
  parameter int WAVE_SIZE = 32,
  parameter int MAX_WAVES = DEFAULT_MAX_WAVES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     block_start,
  input  logic [31:0]              block_id_in,
  input  logic [31:0]              block_dim,
  input  logic [31:0]              num_threads,
  input  logic [NUM_SIMD-1:0]      simd_done,
  output logic                     busy,
  output logic                     block_done,
  output logic [31:0]              block_id,
  output logic [31:0]              num_waves_in_block,
  output logic [NUM_SIMD-1:0][31:0] wave_id,
  output logic [NUM_SIMD-1:0]      simd_ready,
  output logic [NUM_SIMD-1:0]      simd_start,
  output logic [NUM_SIMD-1:0]      simd_working,
  output logic [31:0]              simd_num_threads
`ifdef WAVE_DISPATCHER_PERF_EN
  ,
  output logic [31:0]              block_cycles,
  output logic [31:0]              waves_dispatched
`endif
);

  localparam int CNT_W = $clog2(MAX_WAVES + 1);
  localparam int IDX_W = (NUM_SIMD > 1) ? $clog2(NUM_SIMD) : 1;

  state_e                      state_q, state_d;
  slot_e                       slot_q [NUM_SIMD];
  slot_e                       slot_d [NUM_SIMD];
  logic [31:0]                 block_id_q, block_id_d, block_dim_q, block_dim_d;
  logic [CNT_W-1:0]            num_waves_q, num_waves_d;
  logic [CNT_W-1:0]            next_wave_q, next_wave_d;
  logic [CNT_W-1:0]            waves_done_q, waves_done_d;
  logic [NUM_SIMD-1:0][31:0]   wave_id_q, wave_id_d;
  logic [NUM_SIMD-1:0]         ready_mask, working_mask, start_mask;
  logic [IDX_W-1:0]            free_idx;
  logic                        free_vld, dispatch;
  logic [31:0]                 waves_raw;
  logic [CNT_W-1:0]            waves_clamped, done_cnt;

  always_comb begin
    ready_mask   = '0;
    working_mask = '0;
    start_mask   = '0;
    for (int i = 0; i < NUM_SIMD; i++) begin
      ready_mask[i]   = (slot_q[i] == SLOT_READY);
      start_mask[i]   = (slot_q[i] == SLOT_START);
      working_mask[i] = (slot_q[i] == SLOT_WORKING);
    end
  end

  find_first_free #(.N(NUM_SIMD), .IDX_W(IDX_W)) u_find_first_free (
    .ready_mask_i (ready_mask),
    .idx_o        (free_idx),
    .valid_o      (free_vld)
  );

  assign dispatch      = (state_q == DISPATCH) && free_vld && (next_wave_q != num_waves_q);
  // 32-bit wraparound on the round-up is intentional.
  assign waves_raw     = (block_dim_q + 32'(WAVE_SIZE - 1)) / 32'(WAVE_SIZE);
  assign waves_clamped = (waves_raw > 32'(MAX_WAVES)) ? CNT_W'(MAX_WAVES) : waves_raw[CNT_W-1:0];

  // Only slots actually running a wave may retire one.
  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_SIMD; i++) begin
      if (working_mask[i] && simd_done[i]) done_cnt = done_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    block_id_d   = block_id_q;
    block_dim_d  = block_dim_q;
    num_waves_d  = num_waves_q;
    next_wave_d  = next_wave_q;
    waves_done_d = waves_done_q + done_cnt;
    wave_id_d    = wave_id_q;
    for (int i = 0; i < NUM_SIMD; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i])
        SLOT_START:   slot_d[i] = SLOT_WORKING;
        SLOT_WORKING: if (simd_done[i]) slot_d[i] = SLOT_READY;
        default:      slot_d[i] = slot_q[i];
      endcase
    end
    if (dispatch) begin
      slot_d[free_idx]    = SLOT_START;
      wave_id_d[free_idx] = 32'(next_wave_q);
      next_wave_d         = next_wave_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (block_start) begin
          block_id_d  = block_id_in;
          block_dim_d = block_dim;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        num_waves_d  = waves_clamped;
        next_wave_d  = '0;
        waves_done_d = '0;
        state_d      = (waves_raw == 32'd0) ? DONE : DISPATCH;
      end
      DISPATCH: if (next_wave_d == num_waves_q) state_d = DRAIN;
      DRAIN:    if (waves_done_q == num_waves_q) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      block_id_q   <= '0;
      block_dim_q  <= '0;
      num_waves_q  <= '0;
      next_wave_q  <= '0;
      waves_done_q <= '0;
      wave_id_q    <= '0;
      for (int i = 0; i < NUM_SIMD; i++) slot_q[i] <= SLOT_READY;
    end else begin
      state_q      <= state_d;
      block_id_q   <= block_id_d;
      block_dim_q  <= block_dim_d;
      num_waves_q  <= num_waves_d;
      next_wave_q  <= next_wave_d;
      waves_done_q <= waves_done_d;
      wave_id_q    <= wave_id_d;
      for (int i = 0; i < NUM_SIMD; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign busy               = (state_q != IDLE);
  assign block_done         = (state_q == DONE);
  assign block_id           = block_id_q;
  assign num_waves_in_block = 32'(num_waves_q);
  assign wave_id            = wave_id_q;
  assign simd_ready         = ready_mask;
  assign simd_start         = start_mask;
  assign simd_working       = working_mask;
  assign simd_num_threads   = num_threads;

`ifdef WAVE_DISPATCHER_PERF_EN
  logic [31:0] block_cycles_q, waves_dispatched_q;

  // block_cycles covers every non-IDLE cycle of a block and then holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      block_cycles_q     <= '0;
      waves_dispatched_q <= '0;
    end else begin
      if (state_q == IDLE && block_start) block_cycles_q <= '0;
      else if (state_q != IDLE && block_cycles_q != '1) block_cycles_q <= block_cycles_q + 32'd1;
      if (dispatch) waves_dispatched_q <= waves_dispatched_q + 32'd1;
    end
  end

  assign block_cycles     = block_cycles_q;
  assign waves_dispatched = waves_dispatched_q;
`endif

endmodule

// File: tb/tb_wave_dispatcher.sv
// Directed bench for wave_dispatcher with a dispatch scoreboard (slot, wave_id).
module tb_wave_dispatcher;

  localparam int NUM_SIMD = 4;

  logic                      clk = 1'b0;
  logic                      rst, block_start;
  logic [31:0]               block_id_in, block_dim, num_threads;
  logic [NUM_SIMD-1:0]       simd_done;
  logic                      busy, block_done;
  logic [31:0]               block_id, num_waves_in_block, simd_num_threads;
  logic [NUM_SIMD-1:0][31:0] wave_id;
  logic [NUM_SIMD-1:0]       simd_ready, simd_start, simd_working;
`ifdef WAVE_DISPATCHER_PERF_EN
  logic [31:0]               block_cycles, waves_dispatched;
`endif

  wave_dispatcher #(.NUM_SIMD(NUM_SIMD), .WAVE_SIZE(32), .MAX_WAVES(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .block_start        (block_start),
    .block_id_in        (block_id_in),
    .block_dim          (block_dim),
    .num_threads        (num_threads),
    .simd_done          (simd_done),
    .busy               (busy),
    .block_done         (block_done),
    .block_id           (block_id),
    .num_waves_in_block (num_waves_in_block),
    .wave_id            (wave_id),
    .simd_ready         (simd_ready),
    .simd_start         (simd_start),
    .simd_working       (simd_working),
    .simd_num_threads   (simd_num_threads)
`ifdef WAVE_DISPATCHER_PERF_EN
    ,
    .block_cycles       (block_cycles),
    .waves_dispatched   (waves_dispatched)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int slot;
    int wave;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_dispatched = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic push(input int slot, input int wave);
    exp_t e;
    e.slot = slot;
    e.wave = wave;
    exp_q.push_back(e);
    exp_dispatched++;
  endtask

  task automatic check_start(input string tag);
    exp_t e;
    chk({tag, "_queued"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_start"}, 64'(simd_start), 64'(1 << e.slot));
      chk({tag, "_wave_id"}, 64'(wave_id[e.slot]), 64'(e.wave));
    end
  endtask

  task automatic start_block(input logic [31:0] id, input logic [31:0] dim);
    block_id_in = id;
    block_dim   = dim;
    block_start = 1'b1;
    step();
    block_start = 1'b0;
  endtask

  task automatic pulse_done(input logic [NUM_SIMD-1:0] mask);
    simd_done = mask;
    step();
    simd_done = '0;
  endtask

  initial begin
    rst         = 1'b0;
    block_start = 1'b0;
    block_id_in = '0;
    block_dim   = '0;
    num_threads = 32'd123456;
    simd_done   = '0;
    step();
    step();

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(simd_ready), 64'hF);
    chk("rst_start", 64'(simd_start), 64'd0);
    chk("rst_working", 64'(simd_working), 64'd0);
    chk("rst_done", 64'(block_done), 64'd0);
    chk("rst_wave_id", 64'(wave_id), 64'd0);
    chk("rst_block_id", 64'(block_id), 64'd0);
    chk("rst_num_waves", 64'(num_waves_in_block), 64'd0);
    chk("nthreads_a", 64'(simd_num_threads), 64'd123456);
    rst = 1'b1;
    step();

    // 64 threads: two waves to slots 0 and 1 on consecutive cycles
    push(0, 0);
    push(1, 1);
    start_block(32'd7, 32'd64);
    chk("b64_busy", 64'(busy), 64'd1);
    step();
    chk("b64_no_early_start", 64'(simd_start), 64'd0);
    step();
    check_start("b64_w0");
    step();
    check_start("b64_w1");
    chk("b64_num_waves", 64'(num_waves_in_block), 64'd2);
    chk("b64_block_id", 64'(block_id), 64'd7);
    step();
    chk("b64_drain_no_start", 64'(simd_start), 64'd0);
    chk("b64_working", 64'(simd_working), 64'h3);
    pulse_done(4'b0011);
    chk("b64_done_not_yet", 64'(block_done), 64'd0);
    step();
    chk("b64_done", 64'(block_done), 64'd1);
    step();
    chk("b64_done_once", 64'(block_done), 64'd0);
    chk("b64_idle", 64'(busy), 64'd0);
    chk("b64_hold_id", 64'(block_id), 64'd7);
    chk("b64_hold_wid", 64'(wave_id[1]), 64'd1);

    // 33 threads round up to two waves
    push(0, 0);
    push(1, 1);
    start_block(32'd8, 32'd33);
    step();
    step();
    check_start("b33_w0");
    step();
    check_start("b33_w1");
    chk("b33_num_waves", 64'(num_waves_in_block), 64'd2);
    step();
    pulse_done(4'b0011);
    step();
    chk("b33_done", 64'(block_done), 64'd1);
    step();

    // Empty block: straight SETUP -> DONE, nothing dispatched
    start_block(32'd9, 32'd0);
    chk("b0_not_done_setup", 64'(block_done), 64'd0);
    step();
    chk("b0_done", 64'(block_done), 64'd1);
    chk("b0_no_start", 64'(simd_start), 64'd0);
    chk("b0_num_waves", 64'(num_waves_in_block), 64'd0);
    step();
    chk("b0_idle", 64'(busy), 64'd0);
    chk("b0_done_once", 64'(block_done), 64'd0);

    // 192 threads: six waves, refills on freed slots
    push(0, 0);
    push(1, 1);
    push(2, 2);
    push(3, 3);
    start_block(32'd10, 32'd192);
    step();
    step();
    check_start("b192_w0");
    step();
    check_start("b192_w1");
    step();
    check_start("b192_w2");
    step();
    check_start("b192_w3");
    push(2, 4);
    pulse_done(4'b0100);
    chk("b192_freed_no_start", 64'(simd_start), 64'd0);
    chk("b192_ready_s2", 64'(simd_ready), 64'h4);
    step();
    check_start("b192_w4");
    push(0, 5);
    pulse_done(4'b1001);
    step();
    check_start("b192_w5");
    chk("b192_ready_s3", 64'(simd_ready), 64'h8);
    step();
    // slot 3 is idle here, so its done bit must not count
    pulse_done(4'b1110);
    chk("b192_not_done_a", 64'(block_done), 64'd0);
    pulse_done(4'b0001);
    chk("b192_not_done_b", 64'(block_done), 64'd0);
    step();
    chk("b192_done", 64'(block_done), 64'd1);
    step();
    chk("b192_done_once", 64'(block_done), 64'd0);
    chk("b192_idle", 64'(busy), 64'd0);

    // block_start during DRAIN is dropped
    push(0, 0);
    push(1, 1);
    start_block(32'd11, 32'd64);
    step();
    step();
    check_start("drop_w0");
    step();
    check_start("drop_w1");
    start_block(32'd99, 32'd32);
    chk("drop_block_id", 64'(block_id), 64'd11);
    chk("drop_busy", 64'(busy), 64'd1);
    chk("drop_no_start_a", 64'(simd_start), 64'd0);
    step();
    chk("drop_no_start_b", 64'(simd_start), 64'd0);
    pulse_done(4'b0011);
    step();
    chk("drop_done", 64'(block_done), 64'd1);
    step();
    chk("drop_done_once", 64'(block_done), 64'd0);
    chk("drop_idle", 64'(busy), 64'd0);
    chk("drop_block_id_end", 64'(block_id), 64'd11);

    // Oversized block clamps to MAX_WAVES; reset abandons it mid-dispatch
    push(0, 0);
    push(1, 1);
    push(2, 2);
    start_block(32'd12, 32'd1280);
    step();
    chk("clamp_num_waves", 64'(num_waves_in_block), 64'd32);
    step();
    check_start("rstmid_w0");
    step();
    check_start("rstmid_w1");
    step();
    check_start("rstmid_w2");
    chk("rstmid_working", 64'(simd_working), 64'h3);
    rst = 1'b0;
    exp_dispatched = 0;
    step();
    chk("rstmid_ready", 64'(simd_ready), 64'hF);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_done", 64'(block_done), 64'd0);
    chk("rstmid_wave_id", 64'(wave_id), 64'd0);
    rst = 1'b1;
    step();
    chk("rstmid_no_done", 64'(block_done), 64'd0);
    push(0, 0);
    push(1, 1);
    start_block(32'd13, 32'd64);
    step();
    step();
    check_start("after_rst_w0");
    step();
    check_start("after_rst_w1");
    step();
    pulse_done(4'b0011);
    step();
    chk("after_rst_done", 64'(block_done), 64'd1);
    step();

    num_threads = 32'hDEAD_BEEF;
    #1;
    chk("nthreads_b", 64'(simd_num_threads), 64'hDEAD_BEEF);

`ifdef WAVE_DISPATCHER_PERF_EN
    // One wave, done sampled 5 edges after the start pulse appears:
    // SETUP 1 + DISPATCH 1 + DRAIN 6 + DONE 1 = 9 cycles.
    push(0, 0);
    start_block(32'd14, 32'd32);
    step();
    step();
    check_start("perf_w0");
    step();
    step();
    step();
    step();
    pulse_done(4'b0001);
    step();
    chk("perf_done", 64'(block_done), 64'd1);
    step();
    chk("perf_block_cycles", 64'(block_cycles), 64'd9);
    chk("perf_waves_dispatched", 64'(waves_dispatched), 64'(exp_dispatched));
    step();
    chk("perf_block_cycles_hold", 64'(block_cycles), 64'd9);
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
